// File: rtl/simd_pkg.sv
// ---------------------------------------------------------------------------
// simd_pkg
// Shared types and default sizes for the SIMD vector engine.
//   - DEF_MEM_SIZE / DEF_ADDR_W / DEF_DATA_W : default shared-memory geometry
//   - op_e    : element operation encoding carried in every command
//   - cmd_t   : packed 35-bit queue command {op, dst, src_a, src_b, len}
//   - state_e : issuer/ALU sequencer states
// ---------------------------------------------------------------------------
package simd_pkg;

  localparam int DEF_MEM_SIZE = 256;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_COPY = 3'd7
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] dst;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic [7:0] len;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    WR   = 2'd3
  } state_e;

endpackage

// File: rtl/simd_shared_mem.sv
// ---------------------------------------------------------------------------
// simd_mem_array / shared_mem
// Single-port word memory shared by the SIMD engine. One address per cycle;
// the read data appears one cycle after the address (registered read) and a
// write lands on the same rising edge. Contents have no reset: the array is
// preloaded and inspected from outside through u_mem.r_mem.
//   i_clk   : clock, all activity on the rising edge
//   i_we    : write enable for i_addr
//   i_addr  : word address (read and write share it)
//   i_wdata : write data
//   o_rdata : data of the address presented on the previous cycle
// ---------------------------------------------------------------------------
module simd_mem_array
  import simd_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:MEM_SIZE-1];
  logic [DATA_W-1:0] r_rdata;

  // Storage plus registered read port. The read returns the old contents on
  // a same-address write, but the engine never reads and writes together.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

module shared_mem
  import simd_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Thin wrapper so the array sits at a stable hierarchical path.
  simd_mem_array #(
    .MEM_SIZE (MEM_SIZE),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata)
  );

endmodule

// File: rtl/simd_top.sv
// ---------------------------------------------------------------------------
// simd_top
// Command-driven vector engine. Pops one command at a time from an external
// queue and applies mem[dst+k] = op(mem[src_a+k], mem[src_b+k]) for
// k = 0..len-1, three cycles per element (read a, read b, write).
//   i_clk           : clock
//   i_rst           : synchronous active-high reset (aborts a running command)
//   queue_cmd       : head-of-queue command, valid when queue_empty = 0
//   queue_empty     : 1 = no command waiting
//   issuer_rd_queue : pop strobe, queue_cmd is consumed on this rising edge
//   finished_task   : engine idle and nothing left in the queue
// ---------------------------------------------------------------------------
module simd_top
  import simd_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  cmd_t queue_cmd,
  input  logic queue_empty,
  output logic issuer_rd_queue,
  output logic finished_task
);

  state_e            r_state;
  state_e            w_nextState;
  cmd_t              r_cmd;
  logic [7:0]        r_k;
  logic [DATA_W-1:0] r_opA;

  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memRdata;
  logic [DATA_W-1:0] w_result;
  logic              w_lastElem;
  logic              w_skipCmd;

  // Element addresses wrap naturally by truncating to the memory index width.
  function automatic logic [ADDR_W-1:0] wrapAddr(input logic [7:0] base,
                                                 input logic [7:0] k);
    return ADDR_W'(base) + ADDR_W'(k);
  endfunction

  // Pop only from IDLE and never while reset is held, so a command cannot be
  // lost into a sequencer that is about to be cleared.
  assign issuer_rd_queue = (r_state == IDLE) && !queue_empty && !i_rst;
  assign finished_task   = (r_state == IDLE) && queue_empty;
  assign w_lastElem      = (r_k == r_cmd.len - 8'd1);
  assign w_skipCmd       = (queue_cmd.op == OP_NOP) || (queue_cmd.len == 8'd0);

  // Element ALU. Operand a was captured in RD_B; operand b is taken straight
  // from the memory read port during WR, where its data has just arrived.
  always_comb begin
    w_result = '0;
    case (r_cmd.op)
      OP_ADD:  w_result = r_opA + w_memRdata;
      OP_SUB:  w_result = r_opA - w_memRdata;
      OP_MUL:  w_result = r_opA * w_memRdata;
      OP_AND:  w_result = r_opA & w_memRdata;
      OP_OR:   w_result = r_opA | w_memRdata;
      OP_XOR:  w_result = r_opA ^ w_memRdata;
      OP_COPY: w_result = r_opA;
      default: w_result = '0;
    endcase
  end

  // Next-state and memory port control. The single memory port is time
  // shared: src_a in RD_A, src_b in RD_B, dst in WR. Write is suppressed
  // while reset is asserted so an aborted element never lands.
  always_comb begin
    w_nextState = r_state;
    w_memWe     = 1'b0;
    w_memAddr   = wrapAddr(r_cmd.src_a, r_k);
    case (r_state)
      IDLE: begin
        if (issuer_rd_queue && !w_skipCmd) begin
          w_nextState = RD_A;
        end
      end
      RD_A: begin
        w_memAddr   = wrapAddr(r_cmd.src_a, r_k);
        w_nextState = RD_B;
      end
      RD_B: begin
        w_memAddr   = wrapAddr(r_cmd.src_b, r_k);
        w_nextState = WR;
      end
      WR: begin
        w_memAddr   = wrapAddr(r_cmd.dst, r_k);
        w_memWe     = !i_rst;
        w_nextState = w_lastElem ? IDLE : RD_A;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Sequencer registers: state, latched command, element index and the
  // captured first operand. A pop latches the command and restarts k even
  // for NOP/zero-length commands, which simply never leave IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_k     <= '0;
      r_opA   <= '0;
    end else begin
      r_state <= w_nextState;
      if (issuer_rd_queue) begin
        r_cmd <= queue_cmd;
        r_k   <= '0;
      end
      if (r_state == RD_B) begin
        r_opA <= w_memRdata;
      end
      if (r_state == WR && !w_lastElem) begin
        r_k <= r_k + 8'd1;
      end
    end
  end

  shared_mem #(
    .MEM_SIZE (MEM_SIZE),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_shared_mem (
    .i_clk   (i_clk),
    .i_we    (w_memWe),
    .i_addr  (w_memAddr),
    .i_wdata (w_result),
    .o_rdata (w_memRdata)
  );

endmodule

// File: tb/tb_simd_top.sv
// ---------------------------------------------------------------------------
// tb_simd_top
// Directed bench for simd_top: a small command queue model feeds the DUT,
// memory is preloaded/inspected through u_shared_mem.u_mem.r_mem, and
// expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_simd_top;
  import simd_pkg::*;

  logic i_clk;
  logic i_rst;
  cmd_t queue_cmd;
  logic queue_empty;
  logic issuer_rd_queue;
  logic finished_task;

  simd_top dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .queue_cmd       (queue_cmd),
    .queue_empty     (queue_empty),
    .issuer_rd_queue (issuer_rd_queue),
    .finished_task   (finished_task)
  );

  // 10 ns clock; the bench drives and samples around the falling edge.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } aluVec_t;

  cmd_t qMem [0:63];
  int   qHead;
  int   qCount;
  int   popCycles [0:63];
  int   popCount;
  int   cycleNum;
  int   vecCount;
  int   missCount;

  aluVec_t vecs [0:9];

  // Hard stop in case the stimulus itself ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic cmd_t mkCmd(input op_e op, input int dst, input int a,
                                 input int b, input int len);
    cmd_t c;
    c.op    = op;
    c.dst   = 8'(dst);
    c.src_a = 8'(a);
    c.src_b = 8'(b);
    c.len   = 8'(len);
    return c;
  endfunction

  task automatic pokeMem(input int addr, input logic [31:0] val);
    dut.u_shared_mem.u_mem.r_mem[8'(addr)] <= val;
  endtask

  function automatic logic [31:0] peekMem(input int addr);
    return dut.u_shared_mem.u_mem.r_mem[8'(addr)];
  endfunction

  // Push a command into the queue model.
  task automatic applyStimulus(input cmd_t c);
    if (qCount < 64) begin
      qMem[qCount] = c;
      qCount++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge. The pop strobe is
  // sampled 1 ns later, which is exactly what the DUT sees at the next rise.
  task automatic oneCycle(output logic finNow);
    logic popNow;
    queue_empty = (qHead >= qCount);
    queue_cmd   = (qHead >= qCount) ? cmd_t'('0) : qMem[qHead];
    #1;
    finNow = finished_task;
    popNow = issuer_rd_queue;
    if (popNow && popCount < 64) begin
      popCycles[popCount] = cycleNum;
      popCount++;
    end
    @(posedge i_clk);
    if (popNow) qHead++;
    @(negedge i_clk);
    cycleNum++;
  endtask

  task automatic runUntilIdle(input int budget, input string name,
                              output int doneAt);
    logic fin;
    doneAt = -1;
    for (int c = 0; c < budget; c++) begin
      oneCycle(fin);
      if (fin) begin
        doneAt = cycleNum - 1;
        break;
      end
    end
    if (doneAt < 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s_timeout: no finished_task within %0d cycles", name, budget);
    end
  endtask

  task automatic checkPopGap(input string name, input int idxA, input int idxB,
                             input int expGap);
    if (idxB < popCount) begin
      checkOutput(name, 32'(popCycles[idxB] - popCycles[idxA]), 32'(expGap));
    end else begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s: pop %0d missing (pops seen %0d)", name, idxB, popCount);
    end
  endtask

  initial begin
    int   done;
    int   startPop;
    logic fin;

    vecs[0] = '{OP_ADD,  32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 4};
    vecs[1] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 4};
    vecs[2] = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4};
    vecs[3] = '{OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4};
    vecs[4] = '{OP_MUL,  32'h0000_0003, 32'h8000_0001, 32'h8000_0003, 4};
    vecs[5] = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4};
    vecs[6] = '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 4};
    vecs[7] = '{OP_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 4};
    vecs[8] = '{OP_COPY, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 4};
    vecs[9] = '{OP_NOP,  32'h1111_1111, 32'h2222_2222, 32'hCAFE_F00D, 1};

    qHead = 0; qCount = 0; popCount = 0; cycleNum = 0;
    vecCount = 0; missCount = 0;
    i_rst = 1'b1;
    queue_empty = 1'b1;
    queue_cmd = '0;

    for (int i = 0; i < 4; i++) begin
      pokeMem(i, 32'(i + 1));
      pokeMem(16 + i, 32'((i + 1) * 10));
    end

    // Reset with an empty queue: idle, finished, no pop strobe.
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) oneCycle(fin);
    #1;
    checkOutput("rst_finished", 32'(finished_task), 32'd1);
    checkOutput("rst_rdq_idle", 32'(issuer_rd_queue), 32'd0);

    // A command waiting while reset is held must not be popped.
    applyStimulus(mkCmd(OP_ADD, 32, 0, 16, 4));
    for (int i = 0; i < 2; i++) oneCycle(fin);
    checkOutput("rst_no_pop", 32'(popCount), 32'd0);
    checkOutput("rst_busy_flag", 32'(fin), 32'd0);

    // Four-element ADD, done 13 cycles after the pop.
    $display("[TB] basic ADD len=4");
    i_rst = 1'b0;
    runUntilIdle(60, "add4", done);
    checkOutput("add4_pops", 32'(popCount), 32'd1);
    if (popCount > 0 && done >= 0)
      checkOutput("add4_latency", 32'(done - popCycles[0]), 32'd13);
    checkOutput("add4_m32", peekMem(32), 32'd11);
    checkOutput("add4_m33", peekMem(33), 32'd22);
    checkOutput("add4_m34", peekMem(34), 32'd33);
    checkOutput("add4_m35", peekMem(35), 32'd44);

    // Single-element operation table.
    $display("[TB] op table");
    for (int v = 0; v < 10; v++) begin
      pokeMem(100, vecs[v].a);
      pokeMem(101, vecs[v].b);
      pokeMem(102, 32'hCAFE_F00D);
      startPop = popCount;
      applyStimulus(mkCmd(vecs[v].op, 102, 100, 101, 1));
      runUntilIdle(20, $sformatf("vec%0d", v), done);
      checkOutput($sformatf("vec%0d_result", v), peekMem(102), vecs[v].expRes);
      if (popCount > startPop && done >= 0)
        checkOutput($sformatf("vec%0d_latency", v),
                    32'(done - popCycles[startPop]), 32'(vecs[v].expLat));
      else
        checkOutput($sformatf("vec%0d_popped", v), 32'(popCount - startPop), 32'd1);
    end

    // Back-to-back dependent commands: the second reads the first's output.
    $display("[TB] dependent pair");
    startPop = popCount;
    applyStimulus(mkCmd(OP_ADD, 40, 0, 16, 2));
    applyStimulus(mkCmd(OP_ADD, 48, 40, 40, 2));
    runUntilIdle(60, "dep", done);
    checkPopGap("dep_pop_gap", startPop, startPop + 1, 7);
    checkOutput("dep_m40", peekMem(40), 32'd11);
    checkOutput("dep_m41", peekMem(41), 32'd22);
    checkOutput("dep_m48", peekMem(48), 32'd22);
    checkOutput("dep_m49", peekMem(49), 32'd44);

    // NOP and zero-length commands pop in one cycle with no memory effect.
    $display("[TB] nop / len0");
    pokeMem(60, 32'hDEAD_0060);
    pokeMem(61, 32'hDEAD_0061);
    pokeMem(62, 32'hDEAD_0062);
    startPop = popCount;
    applyStimulus(mkCmd(OP_NOP, 60, 0, 16, 3));
    applyStimulus(mkCmd(OP_ADD, 61, 0, 16, 0));
    applyStimulus(mkCmd(OP_COPY, 62, 3, 0, 1));
    runUntilIdle(30, "nop", done);
    checkPopGap("nop_gap1", startPop, startPop + 1, 1);
    checkPopGap("nop_gap2", startPop + 1, startPop + 2, 1);
    checkOutput("nop_m60", peekMem(60), 32'hDEAD_0060);
    checkOutput("len0_m61", peekMem(61), 32'hDEAD_0061);
    checkOutput("after_nop_m62", peekMem(62), 32'd4);

    // Reset during element 2 of a len=4 ADD: elements 0-1 stay written.
    $display("[TB] mid-command reset");
    for (int i = 70; i < 74; i++) pokeMem(i, 32'hBEEF_0000 + 32'(i));
    startPop = popCount;
    applyStimulus(mkCmd(OP_ADD, 70, 0, 16, 4));
    for (int c = 0; c < 10 && popCount == startPop; c++) oneCycle(fin);
    checkOutput("abort_popped", 32'(popCount - startPop), 32'd1);
    for (int c = 0; c < 7; c++) oneCycle(fin);
    i_rst = 1'b1;
    oneCycle(fin);
    startPop = popCount;
    applyStimulus(mkCmd(OP_ADD, 80, 0, 16, 1));
    oneCycle(fin);
    checkOutput("abort_rst_no_pop", 32'(popCount - startPop), 32'd0);
    i_rst = 1'b0;
    runUntilIdle(20, "abort_next", done);
    checkOutput("abort_m70", peekMem(70), 32'd11);
    checkOutput("abort_m71", peekMem(71), 32'd22);
    checkOutput("abort_m72", peekMem(72), 32'hBEEF_0048);
    checkOutput("abort_m73", peekMem(73), 32'hBEEF_0049);
    checkOutput("abort_next_m80", peekMem(80), 32'd11);

    // COPY across the top of memory wraps back to address 0.
    $display("[TB] address wrap");
    for (int i = 0; i < 4; i++) pokeMem(i, 32'(i + 1));
    pokeMem(254, 32'hDEAD_00FE);
    pokeMem(255, 32'hDEAD_00FF);
    applyStimulus(mkCmd(OP_COPY, 254, 0, 0, 4));
    runUntilIdle(30, "wrap", done);
    checkOutput("wrap_m254", peekMem(254), 32'd1);
    checkOutput("wrap_m255", peekMem(255), 32'd2);
    checkOutput("wrap_m0", peekMem(0), 32'd3);
    checkOutput("wrap_m1", peekMem(1), 32'd4);
    checkOutput("wrap_m2", peekMem(2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
